// File: rtl/complex_row_result_collector_pkg.sv
// Shared definitions for the complex row result collector: complex word layout,
// widths, FSM states and the FIFO entry type.
package complex_row_result_collector_pkg;

    localparam int ELEMENT_WIDTH = 64;
    localparam int INDEX_WIDTH   = 16;

    localparam int RE_MSB = 63;
    localparam int RE_LSB = 32;
    localparam int IM_MSB = 31;
    localparam int IM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0]   index;
        logic [ELEMENT_WIDTH-1:0] data;
    } result_t;

    function automatic result_t make_result(input logic [INDEX_WIDTH-1:0] index,
                                            input logic [ELEMENT_WIDTH-1:0] data);
        result_t r;
        r.index = index;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/complex_row_result_collector_if.sv
// Accumulator-side and result-side handshake bundle of the row result collector.
// The collector uses the slave view; its environment uses the master view.
interface complex_row_result_collector_if;
    import complex_row_result_collector_pkg::*;

    logic                     acc_valid;
    logic [ELEMENT_WIDTH-1:0] acc_data;
    logic                     acc_clear;
    logic                     res_valid;
    logic                     res_ready;
    logic [ELEMENT_WIDTH-1:0] res_data;
    logic [INDEX_WIDTH-1:0]   res_index;

    modport master (
        output acc_valid, acc_data, res_ready,
        input  acc_clear, res_valid, res_data, res_index
    );

    modport slave (
        input  acc_valid, acc_data, res_ready,
        output acc_clear, res_valid, res_data, res_index
    );

endinterface

// File: rtl/complex_row_result_collector_fifo.sv
// Synchronous FIFO of tagged row results. The head word reads as zero while
// empty so stale storage never reaches the outputs.
module complex_result_fifo
    import complex_row_result_collector_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  result_t                wdata_i,
    output result_t                rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    result_t        mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push_s;
    logic           do_pop_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_COUNT);
    assign do_pop_s  = pop_i && !empty_o;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Entry storage written at the tail.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/complex_row_result_collector.sv
// Counts accumulator strobes per row, captures the final row sum tagged with its
// row index into a result FIFO, and pulses acc_clear between rows.
module complex_row_result_collector
    import complex_row_result_collector_pkg::*;
#(
    parameter int CHUNKS_PER_ROW = 4,
    parameter int ROWS           = 64,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    complex_row_result_collector_if.slave bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        overflow_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam logic [7:0]             LAST_CHUNK = 8'(CHUNKS_PER_ROW - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_ROW   = 16'(ROWS - 1);

    state_e                 state_q;
    logic [7:0]             chunk_cnt_q;
    logic [INDEX_WIDTH-1:0] row_cnt_q;
    logic                   acc_clear_q;
    logic                   overflow_q;
    logic                   busy_q;
    logic                   done_q;

    logic    capture_s;
    logic    pop_s;
    logic    drop_s;
    logic    fifo_full_s;
    logic    fifo_empty_s;
    result_t rdata_s;

    assign capture_s = (state_q == ST_RUN) && bus.acc_valid && (chunk_cnt_q == LAST_CHUNK);
    assign pop_s     = bus.res_ready && !fifo_empty_s;
    // A capture with nowhere to go is lost but still advances the row.
    assign drop_s    = capture_s && fifo_full_s && !pop_s;

    complex_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (capture_s),
        .pop_i   (pop_s),
        .wdata_i (make_result(row_cnt_q, bus.acc_data)),
        .rdata_o (rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_o)
    );

    assign bus.res_valid = !fifo_empty_s;
    assign bus.res_data  = rdata_s.data;
    assign bus.res_index = rdata_s.index;
    assign bus.acc_clear = acc_clear_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

    // Pass sequencing, row/chunk counting and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            chunk_cnt_q <= 8'd0;
            row_cnt_q   <= 16'd0;
            acc_clear_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acc_clear_q <= capture_s;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        chunk_cnt_q <= 8'd0;
                        row_cnt_q   <= 16'd0;
                        overflow_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.acc_valid) begin
                        if (capture_s) begin
                            chunk_cnt_q <= 8'd0;
                            row_cnt_q   <= row_cnt_q + 1'b1;
                            if (drop_s) begin
                                overflow_q <= 1'b1;
                            end
                            if (row_cnt_q == LAST_ROW) begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_row_result_collector.sv
// Self-checking bench for complex_row_result_collector: scenario tasks compare the
// DUT against a queue-based reference model and against fixed expected values.
module tb_complex_row_result_collector;
    import complex_row_result_collector_pkg::*;

    localparam int C  = 4;
    localparam int R  = 3;
    localparam int D  = 2;
    localparam int CW = $clog2(D) + 1;
    localparam int VW = 85 + CW;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          busy;
    logic          done;

    complex_row_result_collector_if bus_if ();

    complex_row_result_collector #(
        .CHUNKS_PER_ROW (C),
        .ROWS           (R),
        .FIFO_DEPTH     (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .bus          (bus_if),
        .fifo_count_o (fifo_count),
        .overflow_o   (overflow),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: pass mode, counters and the list of pending results.
    int          m_mode  = M_IDLE;
    int          m_chunk = 0;
    int          m_row   = 0;
    logic [79:0] m_q[$];
    logic        m_ovf   = 1'b0;
    logic        m_clear = 1'b0;
    logic        m_done  = 1'b0;

    logic [63:0] sr_data;

    task automatic model_step();
        int  size_before;
        bit  pop;
        bit  cap;
        if (rst) begin
            m_mode = M_IDLE; m_chunk = 0; m_row = 0; m_q.delete();
            m_ovf = 1'b0; m_clear = 1'b0; m_done = 1'b0;
            return;
        end
        size_before = m_q.size();
        pop = (size_before > 0) && bus_if.res_ready;
        cap = (m_mode == M_RUN) && bus_if.acc_valid && (m_chunk == C - 1);
        m_clear = cap;
        m_done  = 1'b0;
        if (pop) void'(m_q.pop_front());
        case (m_mode)
            M_IDLE: if (start) begin
                m_mode = M_RUN; m_chunk = 0; m_row = 0; m_ovf = 1'b0;
            end
            M_RUN: if (bus_if.acc_valid) begin
                if (cap) begin
                    if (size_before == D && !pop) m_ovf = 1'b1;
                    else m_q.push_back({16'(m_row), bus_if.acc_data});
                    if (m_row == R - 1) m_mode = M_DRAIN;
                    m_row++;
                    m_chunk = 0;
                end else begin
                    m_chunk++;
                end
            end
            M_DRAIN: if (size_before == 0) begin
                m_mode = M_IDLE; m_done = 1'b1;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {bus_if.acc_clear, bus_if.res_valid, bus_if.res_index, bus_if.res_data,
                fifo_count, overflow, busy, done};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [79:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 80'd0;
        return {m_clear, 1'(m_q.size() > 0), head, CW'(m_q.size()), m_ovf,
                1'(m_mode != M_IDLE), m_done};
    endfunction

    task automatic step(input logic s, input logic av, input logic [63:0] ad, input logic rr);
        start = s;
        bus_if.acc_valid = av;
        bus_if.acc_data  = ad;
        bus_if.res_ready = rr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic feed(input string name, input int n, input int valid_pct, input int ready_pct);
        int   sent = 0;
        int   guard = 0;
        logic av;
        logic rr;
        while (sent < n && guard < 1000) begin
            av = ($urandom_range(99) < valid_pct);
            rr = ($urandom_range(99) < ready_pct);
            step(1'b0, av, {$urandom, $urandom}, rr);
            if (av) sent++;
            guard++;
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL %s cycle %0d: dut=%h model=%h", name, guard, dut_vec(), model_vec());
            else n_pass++;
        end
    endtask

    task automatic drain(input string name);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1'b0, 1'($urandom_range(1)), {$urandom, $urandom}, 1'b1);
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL %s_drain cycle %0d: dut=%h model=%h", name, k, dut_vec(), model_vec());
            else n_pass++;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen || busy !== 1'b0)
            $display("FAIL %s_done: seen=%0d busy=%b, want seen=1 busy=0", name, seen, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        n_checks++;
        if (dut_vec() !== '0 || dut_vec() !== model_vec())
            $display("FAIL reset_outputs: got %h want 0", dut_vec());
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single_row();
        step(1'b1, 1'b0, 64'd0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        for (int i = 0; i < C; i++) begin
            step(1'b0, 1'b1, (i == C - 1) ? sr_data : {$urandom, $urandom}, 1'b0);
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL single_row strobe %0d: dut=%h model=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== sr_data || bus_if.res_index !== 16'd0
            || bus_if.acc_clear !== 1'b1)
            $display("FAIL single_result: valid=%b data=%h idx=%0d clr=%b want 1 %h 0 1",
                     bus_if.res_valid, bus_if.res_data, bus_if.res_index, bus_if.acc_clear, sr_data);
        else n_pass++;
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_checks++;
        if (bus_if.acc_clear !== 1'b0 || bus_if.res_valid !== 1'b0)
            $display("FAIL single_pop: clr=%b valid=%b want 0 0", bus_if.acc_clear, bus_if.res_valid);
        else n_pass++;
        feed("single_rest", 2 * C, 100, 100);
        drain("single");
    endtask

    task automatic test_back_to_back();
        int idx[$];
        int clears = 0;
        step(1'b1, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i <= R * C; i++) begin
            step(1'b0, 1'(i < R * C), {$urandom, $urandom}, 1'b1);
            if (bus_if.acc_clear) clears++;
            if (bus_if.res_valid) idx.push_back(int'(bus_if.res_index));
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL b2b cycle %0d: dut=%h model=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (idx.size() != 3 || idx[0] != 0 || idx[1] != 1 || idx[2] != 2 || clears != 3 || overflow !== 1'b0)
            $display("FAIL b2b_summary: results=%0d clears=%0d ovf=%b want 3 3 0", idx.size(), clears, overflow);
        else n_pass++;
        drain("b2b");
    endtask

    task automatic test_overflow();
        logic [63:0] held;
        step(1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 1; i <= R * C; i++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
            if (i == C) held = bus_if.res_data;
            if (i >= C) begin
                n_checks++;
                if (bus_if.res_data !== held || bus_if.res_index !== 16'd0)
                    $display("FAIL ovf_hold %0d: data=%h idx=%0d want %h 0", i, bus_if.res_data, bus_if.res_index, held);
                else n_pass++;
            end
            if (i == 2 * C) begin
                n_checks++;
                if (overflow !== 1'b0 || fifo_count !== CW'(2))
                    $display("FAIL ovf_before: ovf=%b cnt=%0d want 0 2", overflow, fifo_count);
                else n_pass++;
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || fifo_count !== CW'(2) || busy !== 1'b1 || dut_vec() !== model_vec())
            $display("FAIL ovf_after: ovf=%b cnt=%0d busy=%b want 1 2 1", overflow, fifo_count, busy);
        else n_pass++;
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_checks++;
        if (bus_if.res_index !== 16'd1 || fifo_count !== CW'(1))
            $display("FAIL ovf_release: idx=%0d cnt=%0d want 1 1", bus_if.res_index, fifo_count);
        else n_pass++;
        drain("ovf");
    endtask

    task automatic test_push_pop_full();
        step(1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 1; i <= R * C; i++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, 1'(i == R * C));
            n_checks++;
            if (dut_vec() !== model_vec())
                $display("FAIL pp_full strobe %0d: dut=%h model=%h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_checks++;
        if (overflow !== 1'b0 || fifo_count !== CW'(2) || bus_if.res_index !== 16'd1)
            $display("FAIL pp_full_result: ovf=%b cnt=%0d idx=%0d want 0 2 1", overflow, fifo_count, bus_if.res_index);
        else n_pass++;
        drain("pp_full");
    endtask

    task automatic test_reset_mid_pass();
        step(1'b1, 1'b0, 64'd0, 1'b0);
        feed("mid_pre", 5, 100, 0);
        rst = 1'b1;
        step(1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
        rst = 1'b0;
        n_checks++;
        if (dut_vec() !== '0 || dut_vec() !== model_vec())
            $display("FAIL mid_reset: got %h want 0", dut_vec());
        else n_pass++;
        step(1'b1, 1'b0, 64'd0, 1'b0);
        feed("mid_restart", C, 100, 0);
        n_checks++;
        if (bus_if.res_valid !== 1'b1 || bus_if.res_index !== 16'd0)
            $display("FAIL mid_index: valid=%b idx=%0d want 1 0", bus_if.res_valid, bus_if.res_index);
        else n_pass++;
        feed("mid_rest", 2 * C, 100, 100);
        drain("mid");
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, {$urandom, $urandom}, 1'b1);
            n_checks++;
            if (fifo_count !== '0 || bus_if.res_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL spur_idle %0d: cnt=%0d valid=%b busy=%b want 0 0 0", i, fifo_count, bus_if.res_valid, busy);
            else n_pass++;
        end
        step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b1, 64'd1, 1'b0);
        step(1'b0, 1'b1, 64'd2, 1'b0);
        step(1'b1, 1'b1, 64'd3, 1'b0);
        n_checks++;
        if (bus_if.res_valid !== 1'b0 || dut_vec() !== model_vec())
            $display("FAIL spur_start_run: valid=%b want 0", bus_if.res_valid);
        else n_pass++;
        step(1'b0, 1'b1, 64'hA5A5_0000_5A5A_FFFF, 1'b0);
        n_checks++;
        if (bus_if.res_valid !== 1'b1 || bus_if.res_index !== 16'd0 || bus_if.res_data !== 64'hA5A5_0000_5A5A_FFFF)
            $display("FAIL spur_row0: valid=%b idx=%0d data=%h want 1 0 a5a500005a5affff",
                     bus_if.res_valid, bus_if.res_index, bus_if.res_data);
        else n_pass++;
        feed("spur_rest", 2 * C, 100, 100);
        drain("spur");
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b0, 64'd0, 1'($urandom_range(1)));
            feed("random", R * C, 60, 50);
            drain("random");
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus_if.acc_valid = 1'b0;
        bus_if.acc_data  = 64'd0;
        bus_if.res_ready = 1'b0;
        sr_data = 64'd0;
        sr_data[RE_MSB:RE_LSB] = 32'h3F80_0000;
        sr_data[IM_MSB:IM_LSB] = 32'h4000_0000;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_pass();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
